// File: rtl/dmem_pkg.sv
// Shared types and constants for the M-stage data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int DMEM_WORD_BYTES  = 4;
    localparam int DMEM_MAX_LATENCY = 15;

    // Any nonzero byte offset within a word counts as misaligned.
    function automatic logic dmem_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request bus between the pipeline M stage and the data memory.
interface dmem_responder_if;
    logic        MemWriteM;
    logic        MemReadM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        MemStallM;
    logic        AlignErrM;

    modport master (
        output MemWriteM, MemReadM, ALUResultM, WriteDataM,
        input  ReadDataM, MemStallM, AlignErrM
    );

    modport slave (
        input  MemWriteM, MemReadM, ALUResultM, WriteDataM,
        output ReadDataM, MemStallM, AlignErrM
    );
endinterface

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, registered read data.
module dmem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Read register holds the last load until the next read access.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= 32'd0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: latches a request in IDLE, waits out
// the latency counter in BUSY, performs the access, and answers in RESP.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus_if
);
    localparam int AW = $clog2(DEPTH);

    dmem_state_t   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          is_write_q, is_write_d;
    logic          misalign_q, misalign_d;
    logic          align_err_q, align_err_d;
    logic          req_s;
    logic          fire_s;
    logic          we_s;
    logic          re_s;
    logic          addr_unused_s;

    assign req_s         = bus_if.MemWriteM | bus_if.MemReadM;
    assign addr_unused_s = &{1'b0, bus_if.ALUResultM[31:AW+2]};

    // State, counter and request latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            wdata_q     <= 32'd0;
            is_write_q  <= 1'b0;
            misalign_q  <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            is_write_q  <= is_write_d;
            misalign_q  <= misalign_d;
            align_err_q <= align_err_d;
        end
    end

    // Next-state logic; inputs are only sampled while IDLE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        misalign_d = misalign_q;
        fire_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    idx_d      = bus_if.ALUResultM[AW+1:2];
                    wdata_d    = bus_if.WriteDataM;
                    is_write_d = bus_if.MemWriteM;
                    misalign_d = dmem_misaligned(bus_if.ALUResultM);
                    cnt_d      = 4'(LATENCY - 1);
                    state_d    = BUSY;
                end else begin
                    state_d    = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d   = cnt_q - 4'd1;
                end else begin
                    fire_s  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A write landing on a reset edge is dropped; read+write acts as a write.
    assign we_s        = fire_s & is_write_q & ~reset;
    assign re_s        = fire_s & ~is_write_q;
    assign align_err_d = fire_s & misalign_q;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .we_i    (we_s),
        .re_i    (re_s),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (bus_if.ReadDataM)
    );

    assign bus_if.MemStallM = req_s & (state_q != RESP);
    assign bus_if.AlignErrM = align_err_q;
endmodule
